pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Pipeline sequencing controller for the 5-stage core. It drives write-enable and flush for the PC and for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, and handles three events: load-use stalls, taken-branch redirects resolved in MEM, and multi-cycle data-memory waits. It sits beside the datapath. Its inputs are hazard-relevant fields taken from the ID stage and the ID/EX and EX/MEM registers, plus the data-memory handshake.

## Interface
Parameters:
- MEM_TIMEOUT, 255: consecutive memory-wait cycles after which `mem_timeout` sets.

Ports (name, direction, width, meaning):
- clk, in, 1: core clock.
- rst, in, 1: reset. Synchronous and active-high.
- id_rs1_addr, id_rs2_addr, in, 5 each: source register addresses in ID.
- id_uses_rs1, id_uses_rs2, in, 1 each: the instruction in ID reads that source.
- idex_mem_read, in, 1: the ID/EX instruction is a load.
- idex_rd_addr, in, 5: destination register of the ID/EX instruction.
- exmem_branch, in, 1: the EX/MEM instruction is a branch.
- exmem_zero, in, 1: ALU zero flag latched in EX/MEM.
- mem_req, in, 1: the EX/MEM instruction accesses data memory.
- mem_ready, in, 1: data memory completes the access this cycle.
- pc_we, ifid_we, idex_we, exmem_we, memwb_we, out, 1 each: register load enables.
- ifid_flush, idex_flush, exmem_flush, memwb_flush, out, 1 each: load a bubble (all control bits 0) instead of the input.
- pc_sel, out, 1: 1 selects the EX/MEM branch target (pc_addr1); 0 selects PC+4.
- ctrl_state, out, 2: current FSM state.
- mem_timeout, out, 1: sticky memory-wait timeout error.
- stall_cnt, flush_cnt, out, 32 each: performance counters.

## Operation
Derived terms:
- mem_stall = mem_req & ~mem_ready
- taken = exmem_branch & exmem_zero
- lu_hazard = idex_mem_read & (idex_rd_addr != 0) & ((id_uses_rs1 & id_rs1_addr == idex_rd_addr) | (id_uses_rs2 & id_rs2_addr == idex_rd_addr))
- lu_hazard is forced to 0 while in LU_STALL.

Outputs are combinational. Only the highest-priority event below applies in a given cycle. Any enable or flush not named in a case is 0.
1. **mem_stall.** pc/ifid/idex/exmem_we = 0. memwb_we = 1 with memwb_flush = 1. Next state MEM_WAIT.
2. **taken.** pc_sel = 1. All we = 1. ifid_flush, idex_flush and exmem_flush = 1. Next state FLUSH.
3. **lu_hazard.** pc_we = ifid_we = 0. idex_we = 1 with idex_flush = 1. exmem_we = memwb_we = 1. Next state LU_STALL.
4. **Otherwise.** All we = 1, no flush, pc_sel = 0. Next state RUN.

FSM states: RUN = 0, LU_STALL = 1, MEM_WAIT = 2, FLUSH = 3. Every state follows the priority table above. The only state-specific behaviour is the lu_hazard mask in LU_STALL.

A taken branch that arrives during MEM_WAIT is held in the frozen EX/MEM register. It is acted on in the first cycle in which mem_ready is high.

Wait timer:
- Counts consecutive cycles in which mem_stall is true.
- Saturates at MEM_TIMEOUT.
- Clears in any cycle without mem_stall.
- When the count equals MEM_TIMEOUT and mem_stall is still true, mem_timeout sets and stays set until rst.

## Timing
- Reset: while rst is high, all *_we = 0, all *_flush = 1, pc_sel = 0. Registered values after the rst clock edge: ctrl_state = RUN, wait timer = 0, mem_timeout = 0, stall_cnt = flush_cnt = 0.
- Reset mid-stall or mid-wait: the next cycle is RUN with a clean timer. mem_timeout clears.
- A load-use hazard costs exactly 1 bubble cycle.
- A taken branch costs 3 squashed instructions. The redirect is visible at PC on the edge that ends the taken cycle.
- An N-cycle memory wait freezes PC through EX/MEM for N cycles and injects N bubbles into MEM/WB.
- mem_timeout rises on the edge that ends the (MEM_TIMEOUT+1)-th consecutive stalled cycle.

## Configuration
- Macro: `PIPE_HAZARD_CTRL_PERF_EN`.
- Defined:
  - stall_cnt increments on every non-reset cycle with pc_we = 0.
  - flush_cnt increments on every cycle with pc_sel = 1.
  - Both saturate at 32'hFFFF_FFFF.
- Undefined: both ports are present and tied to 0. No counter flops are built.

## Structure
- Shared package `pipe_ctrl_pkg` holds:
  - the 2-bit state typedef and encodings RUN, LU_STALL, MEM_WAIT, FLUSH;
  - the bubble-control constant (all zeros).
- Sub-module `pipe_wait_timer` holds the saturating wait counter plus the sticky timeout flag, parameterised by MEM_TIMEOUT. Its counter width is $clog2(MEM_TIMEOUT+1).

## Test plan
- **Load-use.** rst, then idex_mem_read = 1, idex_rd_addr = 5, id_rs1_addr = 5, id_uses_rs1 = 1 → one cycle with pc_we = ifid_we = 0 and idex_flush = 1. Next cycle is LU_STALL with all we = 1.
- **x0 exclusion.** Same stimulus with idex_rd_addr = 0 → no stall, state stays RUN.
- **Branch.** exmem_branch = exmem_zero = 1 → pc_sel = 1, three flushes, state FLUSH. flush_cnt = 1 when PERF_EN is defined.
- **Memory wait with branch.** mem_req = 1, mem_ready = 0 for 4 cycles with taken = 1 → 4 frozen cycles and 4 MEM/WB bubbles. The redirect happens on the cycle mem_ready = 1. stall_cnt = 4.
- **Timeout.** With MEM_TIMEOUT = 3, hold mem_stall for 5 cycles → mem_timeout = 1 after the 4th edge. It stays 1 after mem_ready, and a later rst clears it.
- **Reset mid-wait.** Assert rst during MEM_WAIT → all we = 0 and all flushes = 1 while rst is high. Afterwards ctrl_state = RUN and the timer is 0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared state encoding and bubble constant for the pipeline sequencing controller
package pipe_ctrl_pkg;
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2,
        FLUSH    = 2'd3
    } ctrl_state_t;
    localparam int CTRL_W = 8;
    localparam logic [CTRL_W-1:0] BUBBLE_CTRL = '0;
endpackage

// File: rtl/pipe_wait_timer.sv
// pipe_wait_timer: saturating consecutive memory-wait counter with sticky timeout flag
module pipe_wait_timer #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic stall,
    output logic timeout
);
    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    logic [CW-1:0] cnt;
    wire at_max = cnt == CW'(MEM_TIMEOUT);
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            timeout <= 1'b0;
        end else begin
            cnt <= !stall ? '0 : at_max ? cnt : cnt + 1'b1;
            if (stall && at_max)
                timeout <= 1'b1;
        end
    end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: load-use / branch / memory-wait sequencing for the 5-stage core.
// Define PIPE_HAZARD_CTRL_PERF_EN to build the stall and flush performance counters.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs1_addr,
    input  logic [4:0]  id_rs2_addr,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic        idex_mem_read,
    input  logic [4:0]  idex_rd_addr,
    input  logic        exmem_branch,
    input  logic        exmem_zero,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        pc_we,
    output logic        ifid_we,
    output logic        idex_we,
    output logic        exmem_we,
    output logic        memwb_we,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        exmem_flush,
    output logic        memwb_flush,
    output logic        pc_sel,
    output logic [1:0]  ctrl_state,
    output logic        mem_timeout,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);
    ctrl_state_t state, state_nx;
    logic [4:0] we;
    logic [3:0] fl;
    wire mem_stall = mem_req & ~mem_ready;
    wire taken     = exmem_branch & exmem_zero;
    wire lu_hazard = (state != LU_STALL) & idex_mem_read & (idex_rd_addr != 5'd0) &
                     ((id_uses_rs1 & (id_rs1_addr == idex_rd_addr)) |
                      (id_uses_rs2 & (id_rs2_addr == idex_rd_addr)));
    // we = {pc, ifid, idex, exmem, memwb}; fl = {ifid, idex, exmem, memwb}
    always_comb begin
        we       = 5'b11111;
        fl       = 4'b0000;
        pc_sel   = 1'b0;
        state_nx = RUN;
        if (rst) begin
            we = 5'b00000;
            fl = 4'b1111;
        end else if (mem_stall) begin
            we       = 5'b00001;
            fl       = 4'b0001;
            state_nx = MEM_WAIT;
        end else if (taken) begin
            fl       = 4'b1110;
            pc_sel   = 1'b1;
            state_nx = FLUSH;
        end else if (lu_hazard) begin
            we       = 5'b00111;
            fl       = 4'b0100;
            state_nx = LU_STALL;
        end
    end
    always_ff @(posedge clk)
        state <= rst ? RUN : state_nx;
    assign {pc_we, ifid_we, idex_we, exmem_we, memwb_we} = we;
    assign {ifid_flush, idex_flush, exmem_flush, memwb_flush} = fl;
    assign ctrl_state = state;
    pipe_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .stall   (mem_stall),
        .timeout (mem_timeout)
    );
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    logic [31:0] stall_q, flush_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!pc_we && stall_q != 32'hFFFF_FFFF)
                stall_q <= stall_q + 32'd1;
            if (pc_sel && flush_q != 32'hFFFF_FFFF)
                flush_q <= flush_q + 32'd1;
        end
    end
    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed vectors with a scoreboard queue checked by a separate monitor
module tb_pipe_hazard_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [4:0] id_rs1_addr = '0, id_rs2_addr = '0, idex_rd_addr = '0;
    logic id_uses_rs1 = 0, id_uses_rs2 = 0, idex_mem_read = 0;
    logic exmem_branch = 0, exmem_zero = 0, mem_req = 0, mem_ready = 0;
    logic pc_we, ifid_we, idex_we, exmem_we, memwb_we;
    logic ifid_flush, idex_flush, exmem_flush, memwb_flush, pc_sel, mem_timeout;
    logic [1:0] ctrl_state;
    logic [31:0] stall_cnt, flush_cnt;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(3)) dut (
        .clk(clk), .rst(rst),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .idex_mem_read(idex_mem_read), .idex_rd_addr(idex_rd_addr),
        .exmem_branch(exmem_branch), .exmem_zero(exmem_zero),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_we(pc_we), .ifid_we(ifid_we), .idex_we(idex_we), .exmem_we(exmem_we), .memwb_we(memwb_we),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush), .memwb_flush(memwb_flush),
        .pc_sel(pc_sel), .ctrl_state(ctrl_state), .mem_timeout(mem_timeout),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    // {we[4:0], flush[3:0], pc_sel, state[1:0], timeout, stall_cnt, flush_cnt}
    typedef logic [76:0] obs_t;
    localparam int K_RUN = 0, K_LU = 1, K_MEM = 2, K_BR = 3, K_RST = 4;

    obs_t  exp_q[$];
    int    id_q[$];
    int    n_vec = 0, n_bad = 0, vec_id = 0;
    logic [31:0] sc_m = 0, fc_m = 0;

    function automatic logic [9:0] pattern(input int k);
        case (k)
            K_LU:    return {5'b00111, 4'b0100, 1'b0};
            K_MEM:   return {5'b00001, 4'b0001, 1'b0};
            K_BR:    return {5'b11111, 4'b1110, 1'b1};
            K_RST:   return {5'b00000, 4'b1111, 1'b0};
            default: return {5'b11111, 4'b0000, 1'b0};
        endcase
    endfunction

    task automatic v(input logic r, input logic req, input logic rdy, input logic br, input logic z,
                     input logic mr, input logic [4:0] rd, input logic u1, input logic [4:0] rs1,
                     input logic u2, input logic [4:0] rs2, input int kind, input logic [1:0] st,
                     input logic to);
        logic [31:0] sc_e, fc_e;
        #1;
        rst = r; mem_req = req; mem_ready = rdy; exmem_branch = br; exmem_zero = z;
        idex_mem_read = mr; idex_rd_addr = rd; id_uses_rs1 = u1; id_rs1_addr = rs1;
        id_uses_rs2 = u2; id_rs2_addr = rs2;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        sc_e = sc_m; fc_e = fc_m;
`else
        sc_e = 0; fc_e = 0;
`endif
        exp_q.push_back({pattern(kind), st, to, sc_e, fc_e});
        id_q.push_back(vec_id);
        vec_id++;
        if (kind == K_RST) begin
            sc_m = 0; fc_m = 0;
        end else begin
            if (kind == K_LU || kind == K_MEM) sc_m++;
            if (kind == K_BR) fc_m++;
        end
        @(posedge clk);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            obs_t e, a;
            int id;
            e = exp_q.pop_front();
            id = id_q.pop_front();
            a = {pc_we, ifid_we, idex_we, exmem_we, memwb_we,
                 ifid_flush, idex_flush, exmem_flush, memwb_flush,
                 pc_sel, ctrl_state, mem_timeout, stall_cnt, flush_cnt};
            n_vec++;
            if (a !== e) begin
                n_bad++;
                $display("FAIL vec%0d: got we=%b fl=%b sel=%b st=%0d to=%b sc=%0d fc=%0d, want we=%b fl=%b sel=%b st=%0d to=%b sc=%0d fc=%0d",
                         id, a[76:72], a[71:68], a[67], a[66:65], a[64], a[63:32], a[31:0],
                         e[76:72], e[71:68], e[67], e[66:65], e[64], e[63:32], e[31:0]);
            end
        end
    end

    initial begin
        @(posedge clk);
        //  rst req rdy br z  mr rd    u1 rs1   u2 rs2   kind   st    to
        v(1, 0, 0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, K_RST, 2'd0, 0);
        v(0, 0, 0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, K_RUN, 2'd0, 0);
        v(0, 0, 0, 0, 0, 1, 5'd5, 1, 5'd5, 0, 5'd0, K_LU,  2'd0, 0);
        v(0, 0, 0, 0, 0, 1, 5'd5, 1, 5'd5, 0, 5'd0, K_RUN, 2'd1, 0);
        v(0, 0, 0, 0, 0, 1, 5'd0, 1, 5'd0, 0, 5'd0, K_RUN, 2'd0, 0);
        v(0, 0, 0, 0, 0, 1, 5'd7, 1, 5'd3, 0, 5'd7, K_RUN, 2'd0, 0);
        v(0, 0, 0, 0, 0, 1, 5'd7, 0, 5'd7, 1, 5'd7, K_LU,  2'd0, 0);
        v(0, 0, 0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, K_RUN, 2'd1, 0);
        v(0, 0, 0, 1, 1, 1, 5'd5, 1, 5'd5, 0, 5'd0, K_BR,  2'd0, 0);
        v(0, 0, 0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, K_RUN, 2'd3, 0);
        v(0, 0, 0, 1, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, K_RUN, 2'd0, 0);
        v(0, 1, 0, 1, 1, 1, 5'd5, 1, 5'd5, 0, 5'd0, K_MEM, 2'd0, 0);
        v(0, 1, 0, 1, 1, 0, 5'd0, 0, 5'd0, 0, 5'd0, K_MEM, 2'd2, 0);
        v(0, 1, 0, 1, 1, 0, 5'd0, 0, 5'd0, 0, 5'd0, K_MEM, 2'd2, 0);
        v(0, 1, 0, 1, 1, 0, 5'd0, 0, 5'd0, 0, 5'd0, K_MEM, 2'd2, 0);
        v(0, 1, 1, 1, 1, 0, 5'd0, 0, 5'd0, 0, 5'd0, K_BR,  2'd2, 1);
        v(0, 0, 0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, K_RUN, 2'd3, 1);
        v(1, 0, 0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, K_RST, 2'd0, 1);
        v(0, 0, 0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, K_RUN, 2'd0, 0);
        v(0, 1, 0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, K_MEM, 2'd0, 0);
        v(0, 1, 0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, K_MEM, 2'd2, 0);
        v(0, 1, 0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, K_MEM, 2'd2, 0);
        v(0, 0, 0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, K_RUN, 2'd2, 0);
        v(0, 1, 0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, K_MEM, 2'd0, 0);
        v(0, 1, 0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, K_MEM, 2'd2, 0);
        v(0, 1, 0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, K_MEM, 2'd2, 0);
        v(0, 1, 0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, K_MEM, 2'd2, 0);
        v(0, 1, 0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, K_MEM, 2'd2, 1);
        v(0, 1, 1, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, K_RUN, 2'd2, 1);
        v(0, 0, 0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, K_RUN, 2'd0, 1);
        v(0, 1, 0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, K_MEM, 2'd0, 1);
        v(1, 1, 0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, K_RST, 2'd2, 1);
        v(0, 0, 0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, K_RUN, 2'd0, 0);
        v(0, 1, 0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, K_MEM, 2'd0, 0);
        v(0, 1, 0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, K_MEM, 2'd2, 0);
        v(0, 1, 0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, K_MEM, 2'd2, 0);
        v(0, 1, 0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, K_MEM, 2'd2, 0);
        v(0, 0, 0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, K_RUN, 2'd2, 1);
        v(1, 0, 0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, K_RST, 2'd0, 1);
        v(0, 0, 0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, K_RUN, 2'd0, 0);
        for (int i = 0; i < 10 && exp_q.size() > 0; i++)
            @(posedge clk);
        if (exp_q.size() > 0) begin
            n_bad++;
            $display("FAIL drain: %0d vectors left unchecked, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
